// File: rtl/barrel_shifter_pkg.sv
// Shared op codes, payload record and helpers for the pipelined barrel shifter.
package barrel_shifter_pkg;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_AMT_W = 6;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_ROL = 3'b010,
        OP_ROR = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    // Sized for the widest legal configuration; narrower builds leave the upper bits zero.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        logic [2:0]           op;
        logic [MAX_AMT_W-1:0] amt;
        logic                 sign;
        logic                 err;
        logic                 zero;
    } payload_t;

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op > OP_SRA;
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_shift_stage.sv
// One pipeline stage: conditional shift by DIST followed by a valid/payload register.
module shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIST  = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  logic     in_valid,
    input  payload_t in_pay,
    output logic     out_valid,
    output payload_t out_pay
);

    localparam int unsigned BIT = $clog2(DIST);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    payload_t         nxt;

    always_comb begin
        d = in_pay.data[WIDTH-1:0];
        r = d;
        if (in_pay.amt[BIT]) begin
            case (in_pay.op)
                OP_SLL:  r = d << DIST;
                OP_SRL:  r = d >> DIST;
                OP_ROL:  r = (d << DIST) | (d >> (WIDTH - DIST));
                OP_ROR:  r = (d >> DIST) | (d << (WIDTH - DIST));
                OP_SRA:  r = (d >> DIST) | (in_pay.sign ? ~({WIDTH{1'b1}} >> DIST) : '0);
                default: r = d;
            endcase
        end
        nxt                  = in_pay;
        nxt.data[WIDTH-1:0]  = r;
        nxt.amt[BIT]         = 1'b0;
        nxt.zero             = (r == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pay   <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_pay <= nxt;
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Fully pipelined barrel shifter: one registered power-of-two stage per amount bit, MSB first.
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    if (WIDTH < 8 || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0 || AMT_W != $clog2(WIDTH))
    begin : g_bad_params
        $fatal(1, "barrel_shifter_pipe: WIDTH must be a power of two in 8..64 and AMT_W == log2(WIDTH)");
    end

    logic [AMT_W-1:0] vq;
    logic [AMT_W-1:0] vin;
    logic [AMT_W-1:0] rdy;
    logic             acc;
    payload_t         p0;
    payload_t         pin [AMT_W];
    payload_t         pq  [AMT_W];
    logic             unused_tail;

    always_comb begin
        p0                  = '0;
        p0.data[WIDTH-1:0]  = in_data;
        p0.op               = in_op;
        p0.amt[AMT_W-1:0]   = in_amt;
        p0.sign             = in_data[WIDTH-1];
        p0.err              = op_is_reserved(in_op);
    end

    // Ready chain unrolled from the registered valids so no signal feeds back into itself.
    always_comb begin
        acc = out_ready;
        rdy = '0;
        for (int unsigned i = 0; i < AMT_W; i++) begin
            acc                = acc | ~vq[AMT_W-1-i];
            rdy[AMT_W-1-i]     = acc;
        end
    end

    assign vin      = {vq[AMT_W-2:0], in_valid};
    assign in_ready = rdy[0];

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign pin[k] = p0;
        end else begin : g_next
            assign pin[k] = pq[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << (AMT_W - 1 - k))
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (rdy[k]),
            .in_valid  (vin[k]),
            .in_pay    (pin[k]),
            .out_valid (vq[k]),
            .out_pay   (pq[k])
        );
    end

    assign out_valid   = vq[AMT_W-1];
    assign out_data    = pq[AMT_W-1].data[WIDTH-1:0];
    assign out_zero    = pq[AMT_W-1].zero;
    assign out_err     = pq[AMT_W-1].err;
    assign unused_tail = ^pq[AMT_W-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Randomised and directed bench for barrel_shifter_pipe against an arithmetic reference model.
module tb_barrel_shifter_pipe;

    localparam int unsigned W = 16;
    localparam int unsigned A = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [A-1:0]  in_amt = '0;
    logic [2:0]    in_op = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          out_err;

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(W), .AMT_W(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    typedef struct {
        logic [15:0] d;
        logic        z;
        logic        e;
        int          c;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_pop;
    exp_t        e_push;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_outv = 0;
    int          pops = 0;
    int          first_pop = 0;
    int          last_pop = 0;
    bit          lat_chk = 1'b0;
    bit          prev_stall = 1'b0;
    bit          done = 1'b0;
    logic [15:0] prev_d;
    logic        prev_z;
    logic        prev_e;

    logic [2:0]  t_op  [10] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd1, 3'd4, 3'd0, 3'd0, 3'd6, 3'd1};
    logic [15:0] t_dat [10] = '{16'h8001, 16'h0001, 16'h8001, 16'h8000, 16'h8000,
                                16'h4000, 16'h0001, 16'h8000, 16'h1234, 16'h0001};
    logic [3:0]  t_amt [10] = '{4'd1, 4'd1, 4'd4, 4'd15, 4'd15, 4'd14, 4'd0, 4'd1, 4'd5, 4'd15};
    logic [15:0] t_exp [10] = '{16'h0002, 16'h8000, 16'h0018, 16'hFFFF, 16'h0001,
                                16'h0001, 16'h0001, 16'h0000, 16'h1234, 16'h0000};

    function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] d,
                                            input logic [3:0] a);
        logic [31:0] dd;
        dd = {d, d};
        case (op)
            3'd0: return d << a;
            3'd1: return d >> a;
            3'd2: begin dd = dd << a; return dd[31:16]; end
            3'd3: begin dd = dd >> a; return dd[15:0]; end
            3'd4: return $signed(d) >>> a;
            default: return d;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_d));
                chk("hold_zero", 32'(out_zero), 32'(prev_z));
                chk("hold_err", 32'(out_err), 32'(prev_e));
            end
            if (out_valid) n_outv++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e_pop = sb.pop_front();
                    chk("data", 32'(out_data), 32'(e_pop.d));
                    chk("zero", 32'(out_zero), 32'(e_pop.z));
                    chk("err", 32'(out_err), 32'(e_pop.e));
                    if (lat_chk) chk("latency", 32'(cyc - e_pop.c), 32'd4);
                    pops++;
                    if (pops == 1) first_pop = cyc;
                    last_pop = cyc;
                end
            end
            if (in_valid && in_ready) begin
                e_push.d = ref_res(in_op, in_data, in_amt);
                e_push.z = (e_push.d == 16'h0000);
                e_push.e = (in_op > 3'd4);
                e_push.c = cyc;
                sb.push_back(e_push);
                n_acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_z = out_zero;
            prev_e = out_err;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [3:0] a);
        int n;
        n = 0;
        in_op = op;
        in_data = d;
        in_amt = a;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int v0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed beats; each literal also pins the reference model.
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("model_%0d", i), 32'(ref_res(t_op[i], t_dat[i], t_amt[i])), 32'(t_exp[i]));
            send(t_op[i], t_dat[i], t_amt[i]);
        end
        chk("model_rot_keep", 32'(ref_res(3'd2, 16'hA5C3, 4'd7)), 32'h0000E1D2);
        for (int op = 0; op < 5; op++) begin
            chk($sformatf("model_amt0_%0d", op), 32'(ref_res(3'(op), 16'hA5C3, 4'd0)), 32'h0000A5C3);
            send(3'(op), 16'hA5C3, 4'd0);
        end
        drain();

        // Unstalled back-to-back burst: no bubbles, fixed latency.
        pops = 0;
        for (int i = 0; i < 40; i++)
            send(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)));
        drain();
        chk("burst_count", 32'(pops), 32'd40);
        chk("burst_gapless", 32'(last_pop - first_pop), 32'd39);

        // Backpressure: output stalled while 10 beats are offered.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        a0 = n_acc;
        pops = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(3'($urandom_range(0, 4)), 16'($urandom), 4'($urandom_range(0, 15)));
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_accepts", 32'(n_acc - a0), 32'd4);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(pops), 32'd10);
        chk("bp_gapless", 32'(last_pop - first_pop), 32'd9);

        // Random traffic with random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with beats in flight flushes everything.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'd0, 16'h00F0 + 16'(i), 4'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_zero", 32'(out_zero), 32'd0);
        chk("arst_out_err", 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        v0 = n_outv;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("post_reset_quiet", 32'(n_outv - v0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, fully pipelined successor to the team's 16-bit combinational barrel shifter.
- Data width and shift-amount width are generic. Each power-of-two shift stage is followed by a register, so the design closes timing at wide widths.
- Adds arithmetic right shift, a zero-result flag, and valid/ready handshakes with full backpressure on both sides.
- Sits between operand-select logic and the ALU result mux in the datapath.

Parameters:
WIDTH, 16, data width in bits; power of two, 8..64
AMT_W, 4, shift-amount width; must equal log2(WIDTH)

Ports:
clk        in   1        clock, rising-edge
rst_n      in   1        asynchronous active-low reset
in_valid   in   1        input beat valid
in_ready   out  1        block can accept input beat this cycle
in_data    in   WIDTH    operand
in_amt     in   AMT_W    shift amount, 0..WIDTH-1
in_op      in   3        operation code (see Behaviour)
out_valid  out  1        result valid
out_ready  in   1        downstream accepts result
out_data   out  WIDTH    shifted result
out_zero   out  1        out_data == 0
out_err    out  1        op code was reserved

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Op codes:
  - 000 SLL: zero fill from bit 0.
  - 001 SRL: zero fill from MSB.
  - 010 ROL.
  - 011 ROR.
  - 100 SRA: fill with in_data[WIDTH-1].
  - 101..111 reserved: data passes unshifted, out_err=1.
- Pipeline structure:
  - AMT_W stages, indexed k = 0..AMT_W-1.
  - Stage k shifts by 2^(AMT_W-1-k) when its amount bit is 1 (MSB first: 8,4,2,1 for WIDTH=16); otherwise it passes data unchanged.
  - Each stage registers data, op, the remaining amount bits, an err bit, and a valid bit.
  - The SRA sign bit is captured at stage 0 and carried with the beat.
- out_zero is computed combinationally in the last stage and registered with the data.
- Handshake:
  - A beat transfers on in_valid & in_ready; the output transfers on out_valid & out_ready.
  - Stage k advances when ready_k = !valid_k | ready_(k+1); ready_(AMT_W) = out_ready.
  - in_ready = ready_0, combinational from internal valids and out_ready.
- Latency and throughput:
  - Latency is exactly AMT_W cycles from acceptance to out_valid when unstalled.
  - Throughput is 1 beat/cycle.
  - No bubbles are inserted while out_ready=1.
- Stalls:
  - With out_ready=0, out_data/out_zero/out_err hold stable while out_valid=1.
  - Upstream stages keep filling bubbles until all AMT_W stages are full; then in_ready=0.
  - Beats are never dropped or duplicated, and order is preserved.
- Boundary conditions:
  - in_amt=0 returns in_data for all valid ops.
  - Amount WIDTH-1 with SRL/SLL leaves exactly one original bit.
  - Rotate never loses bits.
  - Simultaneous accept and emit in the same cycle when full is legal: occupancy stays constant.
- Reset:
  - All valid bits clear to 0; data, op and err registers clear to 0.
  - out_valid=0, out_data=0, out_zero=0, out_err=0; in_ready=1 after reset.
  - Reset asserted mid-operation flushes all in-flight beats with no output.
- Invalid parameters: WIDTH not a power of two, or AMT_W != log2(WIDTH), is a fatal elaboration error.

Decomposition:
- Package barrel_shifter_pkg holds:
  - op code constants OP_SLL, OP_SRL, OP_ROL, OP_ROR, OP_SRA;
  - an op_is_reserved function;
  - the stage payload struct (data, op, amt, sign, err).
- One sub-module, shift_stage, parametrised by WIDTH and DIST:
  - one combinational conditional shift by DIST plus the valid/ready register slice;
  - instantiated AMT_W times by a generate loop in the top level.

Test Plan (WIDTH=16, AMT_W=4):
- Basic ops, each stimulus -> required response:
  - SLL 0x8001 amt 1 -> out_data 0x0002, zero 0, err 0, out_valid exactly 4 cycles after accept.
  - ROR 0x0001 amt 1 -> 0x8000; ROL 0x8001 amt 4 -> 0x0018.
  - SRA 0x8000 amt 15 -> 0xFFFF; SRL 0x8000 amt 15 -> 0x0001; SRA 0x4000 amt 14 -> 0x0001.
  - SLL 0x0001 amt 0 -> 0x0001; SLL 0x8000 amt 1 -> 0x0000 with out_zero=1.
- Reserved op: op 110, data 0x1234, amt 5 -> out_data 0x1234, out_err=1.
- Backpressure: stream 10 back-to-back beats with out_ready=0 for 8 cycles.
  - in_ready falls after exactly 4 accepts and output holds stable.
  - After release, all 10 results arrive in order with no gaps.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight.
  - Outputs go to 0 immediately, with no results after release.
  - in_ready=1 on the first cycle after deassert.
